ifmap_stream_writer: RTL and testbench

- Transmitter side of the IF buffer write interface of design_top.
- Accepts raw 16-bit IFmap samples over a valid/ready source handshake and tags each one with the 2-bit row-framing code the IF scratchpad expects.
- Pushes the resulting {tag, data} words into the IF FIFO through IF_wen/IF_din, honouring IF_full.
- Replaces hand-driven IF loading; sends row_count rows of row_len elements per start.

---
 rtl/ifmap_stream_writer.sv | 140 ++++++++++++++
 tb/tb_ifmap_stream_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_stream_writer.sv
// IF buffer write-side streamer: tags raw IFmap samples with row framing
// codes and pushes {tag, data} words into the IF FIFO through a one-entry hold.
module ifmap_stream_writer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4,
    parameter int ROW_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  row_len,
    input  logic [ROW_W-1:0]  row_count,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              IF_full,
    output logic              IF_wen,
    output logic [DATA_W+1:0] IF_din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  col_q;
    logic [ROW_W-1:0]  cnt_q;
    logic [ROW_W-1:0]  row_q;
    logic              hold_valid;
    logic [DATA_W+1:0] hold_q;

    logic       launch;
    logic       accept;
    logic       col_first;
    logic       col_last;
    logic       row_last;
    logic [1:0] tag;

    assign launch    = (state == IDLE) & start;
    assign col_first = (col_q == '0);
    assign col_last  = (col_q == len_q - LEN_W'(1));
    assign row_last  = (row_q == cnt_q - ROW_W'(1));

    // A one-element row is both first and last, which yields 2'b11.
    assign tag = {col_first, col_last};

    assign IF_wen = hold_valid & ~IF_full;
    assign IF_din = hold_q;

    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (row_len == '0 || row_count == '0)
                        state_nxt = FIN;
                    else
                        state_nxt = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                src_ready = ~hold_valid | IF_wen;
                accept    = src_valid & src_ready;
                if (accept & col_last & row_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (IF_wen)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Config is only sampled on a start seen in IDLE; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (launch) begin
            len_q <= row_len;
            cnt_q <= row_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (launch) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + LEN_W'(1);
            end
        end
    end

    // Accept and write-out may coincide, keeping one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_q     <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_q     <= {tag, src_data};
        end else if (IF_wen) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Directed bench for ifmap_stream_writer: framing tags, backpressure,
// zero config, reset abandon and start-while-busy.
module tb_ifmap_stream_writer;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;
    localparam int ROW_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  row_len = '0;
    logic [ROW_W-1:0]  row_count = '0;
    logic              src_valid = 1'b0;
    logic [DATA_W-1:0] src_data = '0;
    logic              src_ready;
    logic              IF_full = 1'b0;
    logic              IF_wen;
    logic [DATA_W+1:0] IF_din;
    logic              busy;
    logic              done;

    ifmap_stream_writer #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .ROW_W (ROW_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .row_len  (row_len),
        .row_count(row_count),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_ready(src_ready),
        .IF_full  (IF_full),
        .IF_wen   (IF_wen),
        .IF_din   (IF_din),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int cyc      = 0;
    int wr_cnt   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [17:0] wr_q  [128];
    int          wr_cy [128];
    logic [15:0] samp  [16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (IF_wen) begin
            wr_q[wr_cnt[6:0]]  <= IF_din;
            wr_cy[wr_cnt[6:0]] <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (src_valid && src_ready)
            acc_cnt <= acc_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] word_at(input int i);
        return wr_q[i[6:0]];
    endfunction

    function automatic int cy_at(input int i);
        return wr_cy[i[6:0]];
    endfunction

    task automatic run(input int len, input int cnt, input int nsamp,
                       input int stall_at, input int stall_len,
                       input bit mid_start, input int rst_at,
                       output int b_wr);
        int b_acc, b_done, stalled, k;
        bit fin;
        b_wr    = wr_cnt;
        b_acc   = acc_cnt;
        b_done  = done_cnt;
        stalled = 0;
        fin     = 1'b0;
        @(negedge clk);
        row_len   = LEN_W'(len);
        row_count = ROW_W'(cnt);
        start     = 1'b1;
        src_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < 300; t++) begin
            k         = acc_cnt - b_acc;
            src_valid = (k < nsamp);
            src_data  = samp[k < nsamp ? k[3:0] : 4'd0];
            IF_full   = (wr_cnt - b_wr >= stall_at) && (stalled < stall_len);
            start     = mid_start && (wr_cnt - b_wr == 4);
            if (start) begin
                row_len   = LEN_W'(2);
                row_count = ROW_W'(1);
            end
            if (rst_at >= 0 && wr_cnt - b_wr == rst_at) begin
                IF_full = 1'b1;
                #1;
                chk("rst_pre_ready", src_ready, 0);
                chk("rst_pre_wen", IF_wen, 0);
                rst = 1'b1;
                #1;
                chk("rst_ready", src_ready, 0);
                chk("rst_wen", IF_wen, 0);
                chk("rst_din", IF_din, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                rst       = 1'b0;
                IF_full   = 1'b0;
                src_valid = 1'b0;
                fin       = 1'b1;
                break;
            end
            #1;
            if (IF_full) begin
                stalled++;
                chk("stall_wen", IF_wen, 0);
                chk("stall_ready", src_ready, 0);
            end
            @(negedge clk);
            if (done_cnt != b_done) begin
                fin = 1'b1;
                break;
            end
        end
        src_valid = 1'b0;
        start     = 1'b0;
        IF_full   = 1'b0;
        chk("timeout", fin, 1);
    endtask

    int s1 [12] = '{-77, 95, -1, -54, 59, 6, -47, 15, -65, 30, -45, 54};
    int t12 [12] = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        int b, d0, w0;

        #2;
        chk("reset_ready", src_ready, 0);
        chk("reset_wen", IF_wen, 0);
        chk("reset_din", IF_din, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single 12-element row at full throughput
        for (int i = 0; i < 12; i++) samp[i] = 16'(s1[i]);
        d0 = done_cnt;
        run(12, 1, 12, 0, 0, 1'b0, -1, b);
        chk("s1_count", wr_cnt - b, 12);
        chk("s1_first", word_at(b), 18'h2FFB3);
        chk("s1_second", word_at(b + 1), 18'h0005F);
        chk("s1_last", word_at(b + 11), 18'h10036);
        chk("s1_back2back", cy_at(b + 11) - cy_at(b), 11);
        chk("s1_done_once", done_cnt - d0, 1);
        chk("s1_done_time", done_cyc, cy_at(b + 11) + 1);
        chk("s1_busy_end", busy, 0);
        for (int i = 0; i < 12; i++)
            chk("s1_word", word_at(b + i), {t12[i][1:0], samp[i]});

        // Same stream, IF_full held for 5 cycles after the 3rd write
        d0 = done_cnt;
        run(12, 1, 12, 3, 5, 1'b0, -1, b);
        chk("s2_count", wr_cnt - b, 12);
        chk("s2_fourth", word_at(b + 3), 18'h0FFCA);
        chk("s2_gap", cy_at(b + 3) - cy_at(b + 2), 6);
        chk("s2_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 12; i++)
            chk("s2_word", word_at(b + i), {t12[i][1:0], samp[i]});

        // Two rows of three
        for (int i = 0; i < 6; i++) samp[i] = 16'(i + 1);
        run(3, 2, 6, 0, 0, 1'b0, -1, b);
        chk("s3_count", wr_cnt - b, 6);
        chk("s3_w0", word_at(b), 18'h20001);
        chk("s3_w1", word_at(b + 1), 18'h00002);
        chk("s3_w2", word_at(b + 2), 18'h10003);
        chk("s3_w3", word_at(b + 3), 18'h20004);
        chk("s3_w4", word_at(b + 4), 18'h00005);
        chk("s3_w5", word_at(b + 5), 18'h10006);

        // Single-element rows
        samp[0] = 16'h0007;
        samp[1] = 16'hFFFE;
        run(1, 2, 2, 0, 0, 1'b0, -1, b);
        chk("s3b_count", wr_cnt - b, 2);
        chk("s3b_w0", word_at(b), 18'h30007);
        chk("s3b_w1", word_at(b + 1), 18'h3FFFE);

        // Zero row_len: straight to FIN, no writes
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        row_len   = '0;
        row_count = ROW_W'(4);
        start     = 1'b1;
        src_valid = 1'b1;
        src_data  = 16'h1234;
        #1;
        chk("s4_ready_idle", src_ready, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("s4_done", done, 1);
        chk("s4_busy", busy, 0);
        chk("s4_ready_fin", src_ready, 0);
        @(negedge clk);
        chk("s4_done_low", done, 0);
        chk("s4_ready_after", src_ready, 0);
        repeat (3) @(negedge clk);
        chk("s4_no_writes", wr_cnt - w0, 0);
        chk("s4_done_once", done_cnt - d0, 1);
        src_valid = 1'b0;

        // Reset after 5 writes with the 6th word parked in the hold register
        for (int i = 0; i < 12; i++) samp[i] = 16'(s1[i]);
        run(12, 1, 12, 0, 0, 1'b0, 5, b);
        chk("s5_writes_before", wr_cnt - b, 5);
        repeat (2) @(negedge clk);
        chk("s5_dropped", wr_cnt - b, 5);
        samp[0] = 16'h00AA;
        samp[1] = 16'h0055;
        run(2, 1, 2, 0, 0, 1'b0, -1, b);
        chk("s5_count", wr_cnt - b, 2);
        chk("s5_w0", word_at(b), 18'h200AA);
        chk("s5_w1", word_at(b + 1), 18'h10055);

        // start pulsed mid-transfer with a different row_len
        for (int i = 0; i < 12; i++) samp[i] = 16'(s1[i]);
        d0 = done_cnt;
        run(12, 1, 12, 0, 0, 1'b1, -1, b);
        chk("s6_count", wr_cnt - b, 12);
        chk("s6_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 12; i++)
            chk("s6_word", word_at(b + i), {t12[i][1:0], samp[i]});
        repeat (3) @(negedge clk);
        chk("s6_idle_after", busy, 0);
        chk("s6_no_extra", wr_cnt - b, 12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
